// File: rtl/cia_sub32_serial.sv
// Nibble-serial two's-complement subtractor: r = a + ~b + 1, one DIGIT-wide slice per clock,
// LSB first, with only a registered carry crossing slice boundaries.
module cia_sub32_serial #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             coutres,
    output logic             overflow
);

    localparam int unsigned NSLICE = WIDTH / DIGIT;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] a_sl, b_sl;
    logic [DIGIT:0]   sum;

    always_comb begin
        a_sl = a_q[cnt_q * DIGIT +: DIGIT];
        b_sl = b_q[cnt_q * DIGIT +: DIGIT];
        sum  = {1'b0, a_sl} + {1'b0, ~b_sl} + {{DIGIT{1'b0}}, carry_q};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        carry_d = carry_q;
        r_d     = r_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    work_d  = '0;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                work_d[cnt_q * DIGIT +: DIGIT] = sum[DIGIT-1:0];
                carry_d = sum[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NSLICE - 1)) begin
                    r_d     = work_d;
                    cout_d  = sum[DIGIT];
                    ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ work_d[WIDTH-1]);
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            r_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            r_q     <= r_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = done_q;
    assign r        = r_q;
    assign coutres  = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_cia_sub32_serial.sv
// Directed bench for cia_sub32_serial: vector table plus handshake and reset sequences.
module tb_cia_sub32_serial;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] r;
    logic        coutres;
    logic        overflow;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        c;
        logic        o;
    } vec_t;

    vec_t vecs[5];

    cia_sub32_serial #(.WIDTH(32), .DIGIT(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .r       (r),
        .coutres (coutres),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called #1 after an edge; issues a one-cycle start and returns #1 after the accepting edge.
    task automatic launch(input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Returns number of edges until done is seen (bounded at 20).
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 20);
    endtask

    initial begin
        int cyc;
        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{a: 32'h0000_0005, b: 32'h0000_0003, r: 32'h0000_0002, c: 1'b1, o: 1'b0};
        vecs[1] = '{a: 32'h0000_0000, b: 32'h0000_0001, r: 32'hFFFF_FFFF, c: 1'b0, o: 1'b0};
        vecs[2] = '{a: 32'h8000_0000, b: 32'h0000_0001, r: 32'h7FFF_FFFF, c: 1'b1, o: 1'b1};
        vecs[3] = '{a: 32'h7FFF_FFFF, b: 32'hFFFF_FFFF, r: 32'h8000_0000, c: 1'b0, o: 1'b1};
        vecs[4] = '{a: 32'h0001_0000, b: 32'h0000_0001, r: 32'h0000_FFFF, c: 1'b1, o: 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_r", r, 32'd0);
        check("reset_cout", {31'd0, coutres}, 32'd0);
        check("reset_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            launch(vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            wait_done(cyc);
            check($sformatf("v%0d_latency", i), cyc, 32'd8);
            check($sformatf("v%0d_r", i), r, vecs[i].r);
            check($sformatf("v%0d_cout", i), {31'd0, coutres}, {31'd0, vecs[i].c});
            check($sformatf("v%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].o});
            check($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
        end

        // start while busy must be ignored
        launch(32'd5, 32'd3);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc);
        check("ign_latency", cyc, 32'd5);
        check("ign_r", r, 32'd2);
        @(posedge clk);
        #1;
        check("ign_no_queue", {31'd0, busy}, 32'd0);

        // back-to-back: start held in the done cycle
        launch(32'd0, 32'd1);
        wait_done(cyc);
        check("b2b_first_r", r, 32'hFFFF_FFFF);
        launch(32'd9, 32'd4);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_done_low", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        check("b2b_r_held", r, 32'hFFFF_FFFF);
        wait_done(cyc);
        check("b2b_latency", cyc + 1, 32'd8);
        check("b2b_r", r, 32'd5);
        check("b2b_cout", {31'd0, coutres}, 32'd1);
        check("b2b_ovf", {31'd0, overflow}, 32'd0);

        // reset mid-run: previous r is 5, start 0x80000000-1 so outputs would go nonzero
        @(posedge clk);
        #1;
        launch(32'h8000_0000, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_r", r, 32'd0);
        check("rst_cout", {31'd0, coutres}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) cyc++;
        end
        check("rst_no_done", cyc, 32'd0);
        check("rst_r_after", r, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
